// File: rtl/ddr2_tg_pkg.sv
// Shared constants and helpers for the DDR2 test-data generator/checker.
package ddr2_tg_pkg;

    localparam int unsigned PAT_W  = 16;
    localparam int unsigned LFSR_W = 32;

    localparam logic [PAT_W-1:0] FIXED_PAT0 = 16'hFFFF;
    localparam logic [PAT_W-1:0] FIXED_PAT1 = 16'hAAAA;
    localparam logic [PAT_W-1:0] FIXED_PAT2 = 16'h5555;
    localparam logic [PAT_W-1:0] FIXED_PAT3 = 16'h9999;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic {
        PAT_FIXED = 1'b0,
        PAT_LFSR  = 1'b1
    } pat_mode_e;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : LFSR_W'(0));
    endfunction

    function automatic logic [PAT_W-1:0] fixed_pat(input logic [1:0] idx);
        case (idx)
            2'd0:    return FIXED_PAT0;
            2'd1:    return FIXED_PAT1;
            2'd2:    return FIXED_PAT2;
            default: return FIXED_PAT3;
        endcase
    endfunction

endpackage

// File: rtl/ddr2_pattern_src.sv
// Beat-sequenced pattern source: beat counter, per-burst mode latch and LFSR.
// Presents the word for the current beat; state advances when adv_i is high.
module ddr2_pattern_src
    import ddr2_tg_pkg::*;
#(
    parameter int unsigned DQ_WIDTH  = 16,
    parameter int unsigned BURST_LEN = 4,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_1234
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adv_i,
    input  logic                  pattern_sel_i,
    output logic [2*DQ_WIDTH-1:0] word_c
);

    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned REP16  = (DQ_WIDTH + PAT_W - 1) / PAT_W;
    localparam int unsigned REP32  = (DQ_WIDTH + LFSR_W - 1) / LFSR_W;

    logic [BEAT_W-1:0] beat_q, beat_d;
    pat_mode_e         mode_q, mode_d, mode_c;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [DQ_WIDTH-1:0] pat;

    // Beat 0 takes pattern_sel directly so the first beat of a burst already uses the new mode
    always_comb begin
        beat_d = beat_q;
        mode_d = mode_q;
        lfsr_d = lfsr_q;
        mode_c = (beat_q == '0) ? pat_mode_e'(pattern_sel_i) : mode_q;
        if (mode_c == PAT_LFSR) begin
            pat = DQ_WIDTH'({REP32{lfsr_q}});
        end else begin
            pat = DQ_WIDTH'({REP16{fixed_pat(2'(beat_q))}});
        end
        word_c = {pat, ~pat};
        if (adv_i) begin
            beat_d = beat_q + BEAT_W'(1);
            mode_d = mode_c;
            if (mode_c == PAT_LFSR) begin
                lfsr_d = lfsr_step(lfsr_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
            mode_q <= PAT_FIXED;
            lfsr_q <= LFSR_SEED;
        end else begin
            beat_q <= beat_d;
            mode_q <= mode_d;
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/ddr2_data_gen_chk.sv
// DDR2 backend write-data generator and read-data checker.
// Optional first-mismatch capture ports are enabled by DDR2_ERR_CAPTURE_EN.
module ddr2_data_gen_chk
    import ddr2_tg_pkg::*;
#(
    parameter int unsigned DQ_WIDTH   = 16,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned WR_LATENCY = 4,
    parameter int unsigned ERR_CNT_W  = 16,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_1234
) (
    input  logic                    clk0,
    input  logic                    rst,
    input  logic                    bkend_data_en,
    input  logic                    bkend_rd_data_valid,
    input  logic [2*DQ_WIDTH-1:0]   rd_data_fifo_out,
    input  logic                    pattern_sel,
    output logic [2*DQ_WIDTH-1:0]   app_wdf_data,
    output logic [2*DQ_WIDTH/8-1:0] app_mask_data,
    output logic                    app_wdf_wren,
    output logic [2*DQ_WIDTH-1:0]   app_compare_data,
    output logic                    cmp_error,
    output logic [ERR_CNT_W-1:0]    err_count
`ifdef DDR2_ERR_CAPTURE_EN
    ,
    output logic [2*DQ_WIDTH-1:0]   first_err_data,
    output logic [2*DQ_WIDTH-1:0]   first_err_exp,
    output logic [2:0]              first_err_beat,
    output logic                    first_err_vld
`endif
);

    localparam int unsigned WORD_W = 2 * DQ_WIDTH;
    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [WORD_W-1:0] wr_word_c;
    logic [WORD_W-1:0] rd_word_c;

    ddr2_pattern_src #(
        .DQ_WIDTH (DQ_WIDTH),
        .BURST_LEN(BURST_LEN),
        .LFSR_SEED(LFSR_SEED)
    ) u_wr_src (
        .clk          (clk0),
        .rst          (rst),
        .adv_i        (bkend_data_en),
        .pattern_sel_i(pattern_sel),
        .word_c       (wr_word_c)
    );

    ddr2_pattern_src #(
        .DQ_WIDTH (DQ_WIDTH),
        .BURST_LEN(BURST_LEN),
        .LFSR_SEED(LFSR_SEED)
    ) u_rd_src (
        .clk          (clk0),
        .rst          (rst),
        .adv_i        (bkend_rd_data_valid),
        .pattern_sel_i(pattern_sel),
        .word_c       (rd_word_c)
    );

    // Write delay line; data is zeroed at entry so it stays zero whenever wren is low
    logic              wren_q  [WR_LATENCY];
    logic [WORD_W-1:0] wdata_q [WR_LATENCY];

    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < WR_LATENCY; i++) begin
                wren_q[i]  <= 1'b0;
                wdata_q[i] <= '0;
            end
        end else begin
            wren_q[0]  <= bkend_data_en;
            wdata_q[0] <= bkend_data_en ? wr_word_c : '0;
            for (int unsigned i = 1; i < WR_LATENCY; i++) begin
                wren_q[i]  <= wren_q[i-1];
                wdata_q[i] <= wdata_q[i-1];
            end
        end
    end

    assign app_wdf_wren  = wren_q[WR_LATENCY-1];
    assign app_wdf_data  = wdata_q[WR_LATENCY-1];
    assign app_mask_data = '0;

    logic [WORD_W-1:0]    cmp_q;
    logic [WORD_W-1:0]    rdata_q;
    logic                 rvld_q;
    logic                 cmp_error_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic                 mismatch_c;

    assign mismatch_c = rvld_q && (rdata_q != cmp_q);

    // Read compare: stage 1 aligns expected and returned data, stage 2 flags/counts
    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            cmp_q       <= '0;
            rdata_q     <= '0;
            rvld_q      <= 1'b0;
            cmp_error_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            cmp_q       <= bkend_rd_data_valid ? rd_word_c : '0;
            rdata_q     <= rd_data_fifo_out;
            rvld_q      <= bkend_rd_data_valid;
            cmp_error_q <= mismatch_c;
            if (mismatch_c && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    assign app_compare_data = cmp_q;
    assign cmp_error        = cmp_error_q;
    assign err_count        = err_cnt_q;

`ifdef DDR2_ERR_CAPTURE_EN
    logic [BEAT_W-1:0] rd_cnt_q;
    logic [BEAT_W-1:0] rbeat_q;
    logic [WORD_W-1:0] cap_data_q;
    logic [WORD_W-1:0] cap_exp_q;
    logic [2:0]        cap_beat_q;
    logic              cap_vld_q;

    // First mismatch after reset is captured once and held
    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            rd_cnt_q   <= '0;
            rbeat_q    <= '0;
            cap_data_q <= '0;
            cap_exp_q  <= '0;
            cap_beat_q <= '0;
            cap_vld_q  <= 1'b0;
        end else begin
            if (bkend_rd_data_valid) begin
                rd_cnt_q <= rd_cnt_q + BEAT_W'(1);
                rbeat_q  <= rd_cnt_q;
            end
            if (mismatch_c && !cap_vld_q) begin
                cap_data_q <= rdata_q;
                cap_exp_q  <= cmp_q;
                cap_beat_q <= 3'(rbeat_q);
                cap_vld_q  <= 1'b1;
            end
        end
    end

    assign first_err_data = cap_data_q;
    assign first_err_exp  = cap_exp_q;
    assign first_err_beat = cap_beat_q;
    assign first_err_vld  = cap_vld_q;
`endif

endmodule

// File: tb/tb_ddr2_data_gen_chk.sv
// Self-checking bench for ddr2_data_gen_chk: vector table plus scoreboarded sequences.
module tb_ddr2_data_gen_chk;

    localparam int unsigned LAT = 4;

    logic        clk0 = 1'b0;
    logic        rst;
    logic        bkend_data_en;
    logic        bkend_rd_data_valid;
    logic [31:0] rd_data_fifo_out;
    logic        pattern_sel;
    logic [31:0] app_wdf_data;
    logic [3:0]  app_mask_data;
    logic        app_wdf_wren;
    logic [31:0] app_compare_data;
    logic        cmp_error;
    logic [1:0]  err_count;
`ifdef DDR2_ERR_CAPTURE_EN
    logic [31:0] first_err_data;
    logic [31:0] first_err_exp;
    logic [2:0]  first_err_beat;
    logic        first_err_vld;
`endif

    ddr2_data_gen_chk #(
        .DQ_WIDTH  (16),
        .BURST_LEN (4),
        .WR_LATENCY(LAT),
        .ERR_CNT_W (2),
        .LFSR_SEED (32'hACE1_1234)
    ) dut (
        .clk0               (clk0),
        .rst                (rst),
        .bkend_data_en      (bkend_data_en),
        .bkend_rd_data_valid(bkend_rd_data_valid),
        .rd_data_fifo_out   (rd_data_fifo_out),
        .pattern_sel        (pattern_sel),
        .app_wdf_data       (app_wdf_data),
        .app_mask_data      (app_mask_data),
        .app_wdf_wren       (app_wdf_wren),
        .app_compare_data   (app_compare_data),
        .cmp_error          (cmp_error),
        .err_count          (err_count)
`ifdef DDR2_ERR_CAPTURE_EN
        ,
        .first_err_data     (first_err_data),
        .first_err_exp      (first_err_exp),
        .first_err_beat     (first_err_beat),
        .first_err_vld      (first_err_vld)
`endif
    );

    always #5 clk0 = ~clk0;

    int cyc = 0;
    always @(posedge clk0) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model of both pattern sources (index 0 write, 1 read)
    logic [1:0]  m_beat [2];
    logic        m_mode [2];
    logic [31:0] m_lfsr [2];
    logic [1:0]  em;

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_beat[s] = 2'd0;
            m_mode[s] = 1'b0;
            m_lfsr[s] = 32'hACE1_1234;
        end
        em = 2'd0;
    endtask

    task automatic gen_word(input int s, input logic sel, output logic [31:0] w);
        logic        md;
        logic [15:0] p;
        logic        lsb;
        md = (m_beat[s] == 2'd0) ? sel : m_mode[s];
        m_mode[s] = md;
        if (md) begin
            p   = m_lfsr[s][15:0];
            lsb = m_lfsr[s][0];
            m_lfsr[s] = m_lfsr[s] >> 1;
            if (lsb) m_lfsr[s] = m_lfsr[s] ^ 32'h8020_0003;
        end else begin
            case (m_beat[s])
                2'd0:    p = 16'hFFFF;
                2'd1:    p = 16'hAAAA;
                2'd2:    p = 16'h5555;
                default: p = 16'h9999;
            endcase
        end
        m_beat[s] = m_beat[s] + 2'd1;
        w = {p, ~p};
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] w;
    } exp_t;

    exp_t wr_q [$];
    exp_t cmp_q [$];
    exp_t err_q [$];

    // Output monitor: pops whatever is due this cycle, otherwise expects idle zeros
    always @(negedge clk0) begin
        logic [31:0] ed, ec;
        logic        ew, ee;
        ew = 1'b0; ed = '0; ec = '0; ee = 1'b0;
        if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
            ew = 1'b1; ed = wr_q[0].w; void'(wr_q.pop_front());
        end
        if (cmp_q.size() > 0 && cmp_q[0].cyc == cyc) begin
            ec = cmp_q[0].w; void'(cmp_q.pop_front());
        end
        if (err_q.size() > 0 && err_q[0].cyc == cyc) begin
            ee = err_q[0].w[0]; void'(err_q.pop_front());
            if (ee && em != 2'd3) em = em + 2'd1;
        end
        chk("wren", 32'(app_wdf_wren), 32'(ew));
        chk("wdata", app_wdf_data, ed);
        chk("mask", 32'(app_mask_data), 32'd0);
        chk("cmp_data", app_compare_data, ec);
        chk("cmp_error", 32'(cmp_error), 32'(ee));
        chk("err_count", 32'(err_count), 32'(em));
    end

    // One cycle of stimulus; rd_kind 0 = literal rdata, 1 = expected word, 2 = inverted expected
    task automatic step(input logic en, input logic sel, input logic vld, input logic [31:0] rdata,
                        input int rd_kind, input logic [31:0] xw, input logic [31:0] xc, input bit use_x);
        logic [31:0] mw, mc, rd;
        mw = '0; mc = '0;
        if (en)  gen_word(0, sel, mw);
        if (vld) gen_word(1, sel, mc);
        if (use_x) begin
            mw = xw; mc = xc;
        end
        rd = (rd_kind == 1) ? mc : (rd_kind == 2) ? ~mc : rdata;
        bkend_data_en       = en;
        pattern_sel         = sel;
        bkend_rd_data_valid = vld;
        rd_data_fifo_out    = rd;
        if (en)  wr_q.push_back('{cyc + LAT, mw});
        if (vld) begin
            cmp_q.push_back('{cyc + 1, mc});
            err_q.push_back('{cyc + 2, 32'(rd != mc)});
        end
        @(posedge clk0); #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (wr_q.size() + cmp_q.size() + err_q.size()) > 0; i++) idle();
        idle();
        checks++;
        if ((wr_q.size() + cmp_q.size() + err_q.size()) != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d want=0", wr_q.size() + cmp_q.size() + err_q.size());
            wr_q.delete(); cmp_q.delete(); err_q.delete();
        end
    endtask

    typedef struct {
        logic        en;
        logic        vld;
        logic [31:0] rd;
        logic [31:0] xw;
        logic [31:0] xc;
    } vec_t;

    vec_t tab [$];

    function automatic void add(input logic en, input logic vld, input logic [31:0] rd,
                                input logic [31:0] xw, input logic [31:0] xc);
        tab.push_back('{en, vld, rd, xw, xc});
    endfunction

    function automatic void add_idle(input int n);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endfunction

    initial begin
        rst = 1'b1;
        bkend_data_en = 1'b0; bkend_rd_data_valid = 1'b0;
        rd_data_fifo_out = '0; pattern_sel = 1'b0;
        model_reset();

        // Four back-to-back fixed-pattern writes
        add(1, 0, 0, 32'hFFFF0000, 0); add(1, 0, 0, 32'hAAAA5555, 0);
        add(1, 0, 0, 32'h5555AAAA, 0); add(1, 0, 0, 32'h99996666, 0);
        add_idle(5);
        // Gapped writes 1,0,0,1,1,1
        add(1, 0, 0, 32'hFFFF0000, 0); add_idle(2);
        add(1, 0, 0, 32'hAAAA5555, 0); add(1, 0, 0, 32'h5555AAAA, 0);
        add(1, 0, 0, 32'h99996666, 0);
        add_idle(5);
        // Concurrent write burst and gapped read loopback 1,0,1,1,0,1
        add(1, 1, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000);
        add(1, 0, 0, 32'hAAAA5555, 0);
        add(1, 1, 32'hAAAA5555, 32'h5555AAAA, 32'hAAAA5555);
        add(1, 1, 32'h5555AAAA, 32'h99996666, 32'h5555AAAA);
        add(0, 0, 0, 0, 0);
        add(0, 1, 32'h99996666, 0, 32'h99996666);
        add_idle(5);
        // Corrupted beat 0, then clean remainder of the burst
        add(0, 1, 32'hFFFF0001, 0, 32'hFFFF0000);
        add(0, 1, 32'hAAAA5555, 0, 32'hAAAA5555);
        add(0, 1, 32'h5555AAAA, 0, 32'h5555AAAA);
        add(0, 1, 32'h99996666, 0, 32'h99996666);
        add_idle(5);

        repeat (3) @(posedge clk0);
        #1;
        chk("rst_wren", 32'(app_wdf_wren), 32'd0);
        chk("rst_cmp", app_compare_data, 32'd0);
        chk("rst_errcnt", 32'(err_count), 32'd0);
        rst = 1'b0;

        foreach (tab[i]) step(tab[i].en, 1'b0, tab[i].vld, tab[i].rd, 0, tab[i].xw, tab[i].xc, 1'b1);
        drain();
        chk("errcnt_after_inject", 32'(err_count), 32'd1);
`ifdef DDR2_ERR_CAPTURE_EN
        chk("cap_vld", 32'(first_err_vld), 32'd1);
        chk("cap_beat", 32'(first_err_beat), 32'd0);
        chk("cap_exp", first_err_exp, 32'hFFFF0000);
        chk("cap_data", first_err_data, 32'hFFFF0001);
`endif

        // LFSR mode: 8 beats written and read back in lockstep
        step(1, 1, 1, 0, 1, 32'h1234EDCB, 32'h1234EDCB, 1'b1);
        step(1, 1, 1, 0, 1, 32'h891A76E5, 32'h891A76E5, 1'b1);
        for (int i = 2; i < 8; i++) step(1, 1, 1, 0, 1, 0, 0, 1'b0);
        drain();

        // pattern_sel drops at beat 2; mode holds until the next beat 0
        step(1, 1, 1, 0, 1, 0, 0, 1'b0);
        step(1, 1, 1, 0, 1, 0, 0, 1'b0);
        step(1, 0, 1, 0, 1, 0, 0, 1'b0);
        step(1, 0, 1, 0, 1, 0, 0, 1'b0);
        step(1, 0, 1, 0, 1, 32'hFFFF0000, 32'hFFFF0000, 1'b1);
        for (int i = 1; i < 4; i++) step(1, 0, 1, 0, 1, 0, 0, 1'b0);
        drain();

        // Asynchronous reset between edges in the middle of a burst
        step(1, 0, 1, 0, 1, 0, 0, 1'b0);
        step(1, 0, 1, 0, 2, 0, 0, 1'b0);
        bkend_data_en = 1'b0; bkend_rd_data_valid = 1'b0; rd_data_fifo_out = '0;
        #2;
        rst = 1'b1;
        wr_q.delete(); cmp_q.delete(); err_q.delete();
        model_reset();
        #1;
        chk("arst_wren", 32'(app_wdf_wren), 32'd0);
        chk("arst_wdata", app_wdf_data, 32'd0);
        chk("arst_cmp", app_compare_data, 32'd0);
        chk("arst_cmperr", 32'(cmp_error), 32'd0);
        chk("arst_errcnt", 32'(err_count), 32'd0);
        @(posedge clk0); #1;
        rst = 1'b0;
        step(1, 0, 1, 0, 1, 32'hFFFF0000, 32'hFFFF0000, 1'b1);
        for (int i = 1; i < 4; i++) step(1, 0, 1, 0, 1, 0, 0, 1'b0);
        drain();

        // Five forced mismatches against a 2-bit saturating counter
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 2, 0, 0, 1'b0);
        drain();
        chk("errcnt_sat", 32'(err_count), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
